hwpe_ctrl_job_dispatcher: RTL and testbench



---
 rtl/hwpe_ctrl_job_dispatcher.sv | 194 +++++++++++++++++++
 tb/tb_hwpe_ctrl_job_dispatcher.sv | 330 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/hwpe_ctrl_job_dispatcher.sv
// Autonomous HWPE job sequencer: queues complete descriptors and runs acquire -> register
// programming -> trigger on the control slave's port, bounded by the slave's context count.
module hwpe_ctrl_job_dispatcher #(
  parameter int unsigned N_JOB_REGS      = 8,
  parameter int unsigned FIFO_DEPTH      = 4,
  parameter int unsigned MAX_OUTSTANDING = 2,
  parameter int unsigned ID_WIDTH        = 16,
  parameter int unsigned MASTER_ID       = 1,
  parameter logic [31:0] TRIGGER_ADDR    = 32'h00,
  parameter logic [31:0] ACQUIRE_ADDR    = 32'h04,
  parameter logic [31:0] JOB_BASE_ADDR   = 32'h40,
  parameter int unsigned BACKOFF_CYCLES  = 8,
  localparam int unsigned OW = $clog2(MAX_OUTSTANDING + 1)
) (
  input  logic                       clk_i,
  input  logic                       rst_ni,
  input  logic                       clear_i,
  input  logic                       job_valid_i,
  output logic                       job_ready_o,
  input  logic [N_JOB_REGS-1:0][31:0] job_regs_i,
  output logic                       req_o,
  input  logic                       gnt_i,
  output logic [31:0]                add_o,
  output logic                       wen_o,
  output logic [3:0]                 be_o,
  output logic [31:0]                data_o,
  output logic [ID_WIDTH-1:0]        id_o,
  input  logic                       r_valid_i,
  input  logic [31:0]                r_data_i,
  input  logic                       done_evt_i,
  output logic                       busy_o,
  output logic [OW-1:0]              outstanding_o,
  output logic                       job_done_o,
  output logic                       spurious_o
);

  localparam int unsigned IW = (N_JOB_REGS > 1) ? $clog2(N_JOB_REGS) : 1;
  localparam int unsigned PW = $clog2(FIFO_DEPTH);
  localparam int unsigned BW = (BACKOFF_CYCLES > 1) ? $clog2(BACKOFF_CYCLES) : 1;

  typedef enum logic [2:0] {IDLE, ACQ_REQ, ACQ_WAIT, BACKOFF, WRITE, TRIG} state_e;

  state_e             state_q, state_d;
  logic [IW-1:0]      idx_q, idx_d;
  logic [BW-1:0]      bo_q, bo_d;
  logic               drop_q, drop_d;
  logic [PW:0]        wptr_q, wptr_d, rptr_q, rptr_d;
  logic [OW-1:0]      out_q, out_d;
  logic               spur_q, spur_d, jd_q, jd_d;
  logic               req_q, req_d, wen_q, wen_d;
  logic [31:0]        add_q, add_d, data_q, data_d;

  logic [N_JOB_REGS-1:0][31:0] fifo_q [FIFO_DEPTH];
  logic [N_JOB_REGS-1:0][31:0] head;
  logic full, empty, push, pop;

  assign full  = (wptr_q[PW] != rptr_q[PW]) && (wptr_q[PW-1:0] == rptr_q[PW-1:0]);
  assign empty = (wptr_q == rptr_q);
  assign push  = job_valid_i && !full && !clear_i;
  assign pop   = (state_q == TRIG) && gnt_i && !clear_i;
  assign head  = fifo_q[rptr_q[PW-1:0]];

  always_ff @(posedge clk_i) begin
    if (push) fifo_q[wptr_q[PW-1:0]] <= job_regs_i;
  end

  always_comb begin
    wptr_d = wptr_q + {{PW{1'b0}}, push};
    rptr_d = rptr_q + {{PW{1'b0}}, pop};
    if (clear_i) begin
      wptr_d = '0;
      rptr_d = '0;
    end
  end

  // FSM; drop_q marks an acquire read still in flight from before a clear, so its
  // late response is not mistaken for the answer to a fresh acquire.
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    bo_d    = bo_q;
    drop_d  = drop_q;
    if (drop_q && r_valid_i) drop_d = 1'b0;
    unique case (state_q)
      IDLE:     if (!empty && (out_q < OW'(MAX_OUTSTANDING))) state_d = ACQ_REQ;
      ACQ_REQ:  if (gnt_i) state_d = ACQ_WAIT;
      ACQ_WAIT: if (r_valid_i && !drop_q) begin
                  if (r_data_i[31]) begin
                    state_d = BACKOFF;
                    bo_d    = BW'(BACKOFF_CYCLES - 1);
                  end else begin
                    state_d = WRITE;
                    idx_d   = '0;
                  end
                end
      BACKOFF:  if (bo_q == '0) state_d = ACQ_REQ;
                else bo_d = bo_q - BW'(1);
      WRITE:    if (gnt_i) begin
                  if (idx_q == IW'(N_JOB_REGS - 1)) state_d = TRIG;
                  else idx_d = idx_q + IW'(1);
                end
      TRIG:     if (gnt_i) state_d = IDLE;
      default:  state_d = IDLE;
    endcase
    if (clear_i) begin
      state_d = IDLE;
      idx_d   = '0;
      bo_d    = '0;
      drop_d  = (drop_q && !r_valid_i) || ((state_q == ACQ_WAIT) && !r_valid_i)
                || ((state_q == ACQ_REQ) && gnt_i);
    end
  end

  // Bus outputs are registered from the next state so they change only on a grant.
  always_comb begin
    req_d  = (state_d == ACQ_REQ) || (state_d == WRITE) || (state_d == TRIG);
    wen_d  = 1'b0;
    add_d  = '0;
    data_d = '0;
    unique case (state_d)
      ACQ_REQ: begin
        wen_d = 1'b1;
        add_d = ACQUIRE_ADDR;
      end
      WRITE: begin
        add_d  = JOB_BASE_ADDR + (32'(idx_d) << 2);
        data_d = head[idx_d];
      end
      TRIG:    add_d = TRIGGER_ADDR;
      default: ;
    endcase
  end

  always_comb begin
    out_d  = out_q;
    spur_d = spur_q || (done_evt_i && (out_q == '0));
    jd_d   = done_evt_i && (out_q != '0);
    if (pop && !done_evt_i)                     out_d = out_q + OW'(1);
    else if (!pop && done_evt_i && out_q != '0) out_d = out_q - OW'(1);
    if (clear_i) begin
      out_d  = '0;
      spur_d = 1'b0;
      jd_d   = 1'b0;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= IDLE;
      idx_q   <= '0;
      bo_q    <= '0;
      drop_q  <= 1'b0;
      wptr_q  <= '0;
      rptr_q  <= '0;
      out_q   <= '0;
      spur_q  <= 1'b0;
      jd_q    <= 1'b0;
      req_q   <= 1'b0;
      wen_q   <= 1'b0;
      add_q   <= '0;
      data_q  <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      bo_q    <= bo_d;
      drop_q  <= drop_d;
      wptr_q  <= wptr_d;
      rptr_q  <= rptr_d;
      out_q   <= out_d;
      spur_q  <= spur_d;
      jd_q    <= jd_d;
      req_q   <= req_d;
      wen_q   <= wen_d;
      add_q   <= add_d;
      data_q  <= data_d;
    end
  end

  logic unused_rdata;
  assign unused_rdata = ^r_data_i[30:0];

  assign job_ready_o   = !full;
  assign req_o         = req_q;
  assign wen_o         = wen_q;
  assign add_o         = add_q;
  assign data_o        = data_q;
  assign be_o          = 4'hF;
  assign id_o          = ID_WIDTH'(MASTER_ID);
  assign busy_o        = (state_q != IDLE) || (out_q != '0);
  assign outstanding_o = out_q;
  assign job_done_o    = jd_q;
  assign spurious_o    = spur_q;

endmodule

// File: tb/tb_hwpe_ctrl_job_dispatcher.sv
// Scoreboard bench: stimulus pushes the expected slave transactions per job, a monitor
// pops and compares on every granted request and tracks a count-level job/queue model.
module tb_hwpe_ctrl_job_dispatcher;
  localparam int N = 8;

  logic clk_i = 0, rst_ni = 0, clear_i = 0, job_valid_i = 0;
  logic job_ready_o, req_o, wen_o, busy_o, job_done_o, spurious_o;
  logic [N-1:0][31:0] job_regs_i = '0;
  logic gnt_i = 0, r_valid_i = 0, done_evt_i = 0;
  logic [31:0] add_o, data_o, r_data_i = '0;
  logic [3:0] be_o;
  logic [15:0] id_o;
  logic [1:0] outstanding_o;

  hwpe_ctrl_job_dispatcher dut (
    .clk_i(clk_i), .rst_ni(rst_ni), .clear_i(clear_i),
    .job_valid_i(job_valid_i), .job_ready_o(job_ready_o), .job_regs_i(job_regs_i),
    .req_o(req_o), .gnt_i(gnt_i), .add_o(add_o), .wen_o(wen_o), .be_o(be_o),
    .data_o(data_o), .id_o(id_o), .r_valid_i(r_valid_i), .r_data_i(r_data_i),
    .done_evt_i(done_evt_i), .busy_o(busy_o), .outstanding_o(outstanding_o),
    .job_done_o(job_done_o), .spurious_o(spurious_o)
  );

  always #5 clk_i = ~clk_i;

  typedef struct {
    logic        wen;
    logic [31:0] add;
    logic [31:0] data;
    bit          chk_data;
    bit          is_trig;
  } txn_t;

  txn_t        exp_q[$];
  logic [31:0] resp_q[$];
  int checks = 0, errors = 0;
  int cyc = 0, exp_out = 0, occ = 0, trig_cnt = 0, last_trig_cyc = 0, first_acq_cyc = -1;
  int hold_max = 0;
  bit exp_jd = 0, exp_spur = 0, mon_en = 0;
  bit gnt_always = 0, done_en = 0, done_req = 0, done_on_trig = 0, stall_armed = 0;

  always @(posedge clk_i) cyc <= cyc + 1;

  task automatic chk(input string name, input longint act, input longint expv);
    checks++;
    if (act != expv) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, expv, cyc);
    end
  endtask

  // Monitor: compares every granted request against the scoreboard and tracks the
  // expected in-flight count, queue occupancy, job_done and spurious flags.
  initial begin : monitor
    bit prev_stall, trig, done_ok;
    logic [31:0] prev_add, prev_data;
    logic prev_wen;
    bit bo_track;
    int bo_cnt, run;
    txn_t t;
    prev_stall = 0; bo_track = 0; bo_cnt = 0; run = 0;
    prev_add = '0; prev_data = '0; prev_wen = 0;
    forever begin
      @(negedge clk_i);
      if (!mon_en) continue;
      if (clear_i) begin
        exp_q.delete(); resp_q.delete();
        exp_out = 0; occ = 0; exp_jd = 0; exp_spur = 0;
        prev_stall = 0; bo_track = 0; run = 0;
        continue;
      end
      chk("job_ready", job_ready_o, (occ < 4) ? 1 : 0);
      chk("outstanding", outstanding_o, exp_out);
      chk("job_done", job_done_o, exp_jd);
      chk("spurious", spurious_o, exp_spur);
      if (prev_stall) begin
        chk("hold_req", req_o, 1);
        chk("hold_wen", wen_o, prev_wen);
        chk("hold_add", add_o, prev_add);
        chk("hold_data", data_o, prev_data);
      end
      trig = 0;
      if (req_o && gnt_i) begin
        if (exp_q.size() == 0) begin
          checks++; errors++;
          $display("FAIL txn_unexpected: got wen=%0b add=0x%0h data=0x%0h, required none", wen_o, add_o, data_o);
        end else begin
          t = exp_q.pop_front();
          chk("txn_wen", wen_o, t.wen);
          chk("txn_add", add_o, t.add);
          if (t.chk_data) chk("txn_data", data_o, t.data);
          trig = t.is_trig;
        end
        if (wen_o && first_acq_cyc < 0) first_acq_cyc = cyc;
        if (trig) begin trig_cnt++; last_trig_cyc = cyc; end
      end
      if (bo_track) begin
        if (!req_o) bo_cnt++;
        else begin chk("backoff_gap", bo_cnt, 8); bo_track = 0; end
      end
      if (r_valid_i && r_data_i[31]) begin bo_track = 1; bo_cnt = 0; end
      if (req_o && !gnt_i && !wen_o && add_o == 32'h4C) run++; else run = 0;
      if (run > hold_max) hold_max = run;
      // model updates for the coming edge
      done_ok = done_evt_i && exp_out > 0;
      exp_jd  = done_ok;
      if (done_evt_i && exp_out == 0) exp_spur = 1;
      if (trig && !done_evt_i) exp_out++;
      else if (!trig && done_ok) exp_out--;
      if (job_valid_i && occ < 4) occ++;
      if (trig) occ--;
      prev_stall = req_o && !gnt_i;
      prev_wen = wen_o; prev_add = add_o; prev_data = data_o;
    end
  end

  // Slave: random grants (or a forced stall), read response one cycle after grant.
  initial begin : slave
    bit rd_fire;
    int stall_cnt;
    stall_cnt = 0;
    forever begin
      @(negedge clk_i);
      rd_fire = req_o && gnt_i && wen_o;
      @(posedge clk_i); #1;
      r_valid_i = 0;
      r_data_i  = $urandom;
      if (rd_fire) begin
        r_valid_i = 1;
        r_data_i  = (resp_q.size() != 0) ? resp_q.pop_front() : 32'h0;
      end
      if (stall_armed && req_o && !wen_o && add_o == 32'h4C) begin
        stall_cnt = 5; stall_armed = 0;
      end
      if (stall_cnt > 0) begin gnt_i = 0; stall_cnt--; end
      else gnt_i = gnt_always ? 1'b1 : ($urandom_range(0, 3) != 0);
    end
  end

  initial begin : done_drv
    forever begin
      @(posedge clk_i); #1;
      done_evt_i = 0;
      if (done_req) begin done_evt_i = 1; done_req = 0; end
      else if (done_on_trig && req_o && !wen_o && add_o == 32'h0) begin
        done_evt_i = 1; done_on_trig = 0;
      end else if (done_en && exp_out > 0 && $urandom_range(0, 4) == 0) done_evt_i = 1;
    end
  end

  task automatic push_job(input logic [N-1:0][31:0] regs, input int nref, output int acc);
    int k;
    txn_t t;
    k = 0; acc = -1;
    job_valid_i = 1; job_regs_i = regs;
    forever begin
      @(negedge clk_i);
      if (job_ready_o) break;
      if (++k > 300) break;
      @(posedge clk_i); #1;
    end
    if (k > 300) begin
      checks++; errors++;
      $display("FAIL push_timeout: got ready=0 for 300 cycles, required acceptance");
    end else begin
      acc = cyc;
      for (int r = 0; r <= nref; r++) begin
        resp_q.push_back((r < nref) ? (32'h8000_0000 | $urandom) : ($urandom & 32'h7FFF_FFFF));
        t = '{wen: 1'b1, add: 32'h04, data: 32'h0, chk_data: 0, is_trig: 0};
        exp_q.push_back(t);
      end
      for (int i = 0; i < N; i++) begin
        t = '{wen: 1'b0, add: 32'h40 + 4 * i, data: regs[i], chk_data: 1, is_trig: 0};
        exp_q.push_back(t);
      end
      t = '{wen: 1'b0, add: 32'h00, data: 32'h0, chk_data: 1, is_trig: 1};
      exp_q.push_back(t);
    end
    @(posedge clk_i); #1;
    job_valid_i = 0;
  endtask

  task automatic wait_trig(input int n, input string name);
    int k;
    k = 0;
    while (trig_cnt < n && k < 400) begin @(posedge clk_i); #1; k++; end
    chk(name, trig_cnt, n);
  endtask

  task automatic drain(input string name);
    int k;
    k = 0; done_en = 1;
    while ((exp_q.size() != 0 || exp_out != 0 || busy_o) && k < 3000) begin
      @(posedge clk_i); #1; k++;
    end
    done_en = 0;
    @(negedge clk_i);
    chk(name, busy_o, 0);
  endtask

  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin : stim
    logic [N-1:0][31:0] regs;
    int t, base;
    gnt_always = 1;
    repeat (3) @(posedge clk_i);
    @(negedge clk_i);
    chk("rst_ready", job_ready_o, 1);   chk("rst_req", req_o, 0);
    chk("rst_wen", wen_o, 0);           chk("rst_add", add_o, 0);
    chk("rst_data", data_o, 0);         chk("rst_id", id_o, 1);
    chk("rst_be", be_o, 4'hF);          chk("rst_busy", busy_o, 0);
    chk("rst_out", outstanding_o, 0);   chk("rst_jd", job_done_o, 0);
    chk("rst_spur", spurious_o, 0);
    @(posedge clk_i); #1;
    rst_ni = 1; mon_en = 1;
    @(posedge clk_i); #1;

    // single job, exact latency with grants always high
    for (int i = 0; i < N; i++) regs[i] = 32'h100 + i;
    first_acq_cyc = -1;
    push_job(regs, 0, t);
    wait_trig(1, "single_trig");
    chk("acq_latency", first_acq_cyc - t, 2);
    chk("trig_latency", last_trig_cyc - t, 12);
    @(negedge clk_i);
    chk("single_out", outstanding_o, 1);
    done_req = 1;
    repeat (3) @(negedge clk_i);
    chk("single_done_out", outstanding_o, 0);

    // two refusals then grant of the acquire
    @(posedge clk_i); #1;
    for (int i = 0; i < N; i++) regs[i] = $urandom;
    push_job(regs, 2, t);
    wait_trig(2, "refuse_trig");
    chk("refuse_latency", last_trig_cyc - t, 32);
    drain("refuse_drain");

    // flow limit: 4 jobs, no done events
    @(posedge clk_i); #1;
    base = trig_cnt;
    for (int j = 0; j < 4; j++) begin
      for (int i = 0; i < N; i++) regs[i] = $urandom;
      push_job(regs, 0, t);
    end
    @(negedge clk_i);
    chk("full_ready", job_ready_o, 0);
    repeat (60) @(negedge clk_i);
    chk("flow_trigs", trig_cnt - base, 2);
    chk("flow_out", outstanding_o, 2);
    chk("flow_idle_req", req_o, 0);
    done_req = 1;
    @(posedge clk_i); #1;
    wait_trig(base + 3, "flow_third");
    drain("flow_drain");

    // grant stall at write index 3 under random grants
    @(posedge clk_i); #1;
    gnt_always = 0; stall_armed = 1; hold_max = 0;
    for (int i = 0; i < N; i++) regs[i] = $urandom;
    push_job(regs, 0, t);
    drain("stall_drain");
    chk("stall_held", (hold_max >= 5) ? 1 : 0, 1);

    // trigger and done in the same cycle with one job in flight
    gnt_always = 1;
    @(posedge clk_i); #1;
    base = trig_cnt;
    for (int i = 0; i < N; i++) regs[i] = $urandom;
    push_job(regs, 0, t);
    wait_trig(base + 1, "td_first");
    done_on_trig = 1;
    for (int i = 0; i < N; i++) regs[i] = $urandom;
    push_job(regs, 0, t);
    wait_trig(base + 2, "td_second");
    @(negedge clk_i);
    chk("td_out", outstanding_o, 1);
    drain("td_drain");

    // done with nothing in flight
    done_req = 1;
    repeat (3) @(negedge clk_i);
    chk("spur_set", spurious_o, 1);

    // randomized traffic
    @(posedge clk_i); #1;
    gnt_always = 0; done_en = 1;
    for (int j = 0; j < 20; j++) begin
      for (int i = 0; i < N; i++) regs[i] = $urandom;
      push_job(regs, ($urandom_range(0, 3) == 0) ? $urandom_range(1, 2) : 0, t);
      repeat ($urandom_range(0, 15)) @(posedge clk_i);
      #1;
    end
    drain("rand_drain");
    chk("spur_sticky", spurious_o, 1);

    // clear in the middle of write index 5 with two jobs queued
    @(posedge clk_i); #1;
    gnt_always = 1;
    for (int j = 0; j < 3; j++) begin
      for (int i = 0; i < N; i++) regs[i] = $urandom;
      push_job(regs, 0, t);
    end
    t = 0;
    while (!(req_o && !wen_o && add_o == 32'h54) && t < 100) begin
      @(posedge clk_i); #1; t++;
    end
    chk("clear_reach_idx5", add_o, 32'h54);
    clear_i = 1;
    @(posedge clk_i); #1;
    clear_i = 0;
    @(negedge clk_i);
    chk("clear_req", req_o, 0);
    chk("clear_ready", job_ready_o, 1);
    chk("clear_out", outstanding_o, 0);
    chk("clear_busy", busy_o, 0);
    chk("clear_spur", spurious_o, 0);
    repeat (12) @(negedge clk_i);
    chk("clear_fifo_empty", busy_o | req_o, 0);
    chk("scoreboard_empty", exp_q.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
